// File: rtl/tpu_host_seq.sv
// tpu_host_seq: bus initiator that runs one TPU matrix-multiply job per start.
//
// Sequence: stream A, B (and optionally C) words from a synchronous source RAM
// into the TPU slave port, fire a single-cycle matmul trigger, idle for
// MM_CYCLES, then read back the 2*DIM C half-rows over a valid/ready sink.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, load_c     job request (sampled in IDLE); load_c=0 skips C init
//   busy, done        job in progress / one-cycle completion pulse
//   src_rd_en/addr    source RAM read strobe and word index
//   src_rdata         source RAM data, one cycle after src_rd_en
//   tpu_r_w/addr      TPU bus control (1 = write), address
//   tpu_dataIn        TPU write data
//   tpu_dataOut       TPU read data, combinational from tpu_addr
//   res_valid/ready   result handshake
//   res_data/res_idx  result word and its index (row = idx>>1, half = idx&1)
module tpu_host_seq #(
  parameter int unsigned DIM       = 8,
  parameter int unsigned BITS_C    = 16,
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned DATAW     = 64,
  parameter int unsigned MM_CYCLES = 4 * DIM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_c,
  output logic                       busy,
  output logic                       done,
  output logic                       src_rd_en,
  output logic [$clog2(4*DIM)-1:0]   src_addr,
  input  logic [DATAW-1:0]           src_rdata,
  output logic                       tpu_r_w,
  output logic [ADDRW-1:0]           tpu_addr,
  output logic [DATAW-1:0]           tpu_dataIn,
  input  logic [DATAW-1:0]           tpu_dataOut,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATAW-1:0]           res_data,
  output logic [$clog2(2*DIM)-1:0]   res_idx
);

  localparam int unsigned SrcAw = $clog2(4 * DIM);
  localparam int unsigned ResW  = $clog2(2 * DIM);
  localparam int unsigned WaitW = (MM_CYCLES > 1) ? $clog2(MM_CYCLES) : 1;

  localparam logic [SrcAw-1:0] NumA     = SrcAw'(DIM);
  localparam logic [SrcAw-1:0] NumAb    = SrcAw'(2 * DIM);
  localparam logic [SrcAw-1:0] LastAll  = SrcAw'(4 * DIM - 1);
  localparam logic [SrcAw-1:0] LastAb   = SrcAw'(2 * DIM - 1);
  localparam logic [ResW-1:0]  LastRes  = ResW'(2 * DIM - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(MM_CYCLES - 1);

  localparam logic [ADDRW-1:0] BaseA    = ADDRW'(12'h100);
  localparam logic [ADDRW-1:0] BaseB    = ADDRW'(12'h200);
  localparam logic [ADDRW-1:0] BaseC    = ADDRW'(12'h300);
  localparam logic [ADDRW-1:0] TrigAddr = ADDRW'(12'h400);

  // A C row of DIM elements must fill exactly two bus words.
  if ((DIM < 2) || (DIM > 8) || (MM_CYCLES < 1) || (ADDRW < 12) ||
      (DIM * BITS_C != 2 * DATAW)) begin : g_bad_cfg
    $error("tpu_host_seq: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTrig,
    StWait,
    StRdc,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic               load_c_q, load_c_d;
  logic [SrcAw-1:0]   w_q, w_d;          // next source word to read
  logic               rd_done_q, rd_done_d;
  logic               wr_vld_q, wr_vld_d; // a read issued last cycle; write it now
  logic [SrcAw-1:0]   wr_w_q, wr_w_d;     // source index of the pending write
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [ResW-1:0]    k_q, k_d;

  logic [SrcAw-1:0]   last_w;
  logic [ADDRW-1:0]   wr_addr;

  assign last_w = load_c_q ? LastAll : LastAb;

  // Map a source word index onto its TPU register address.
  always_comb begin
    wr_addr = '0;
    if (wr_w_q < NumA) begin
      wr_addr = BaseA | (ADDRW'(wr_w_q) << 3);
    end else if (wr_w_q < NumAb) begin
      wr_addr = BaseB | (ADDRW'(wr_w_q - NumA) << 3);
    end else begin
      // C half index c = 2r+h, so r<<4 | h<<3 collapses to c<<3.
      wr_addr = BaseC | (ADDRW'(wr_w_q - NumAb) << 3);
    end
  end

  always_comb begin
    state_d    = state_q;
    load_c_d   = load_c_q;
    w_d        = w_q;
    rd_done_d  = rd_done_q;
    wr_vld_d   = 1'b0;
    wr_w_d     = wr_w_q;
    wait_d     = wait_q;
    k_d        = k_q;

    busy       = (state_q != StIdle);
    done       = 1'b0;
    src_rd_en  = 1'b0;
    src_addr   = w_q;
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_idx    = k_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          load_c_d  = load_c;
          w_d       = '0;
          rd_done_d = 1'b0;
          wr_w_d    = '0;
          state_d   = StLoad;
        end
      end

      StLoad: begin
        // Read side: one word per cycle until the terminal index is issued.
        if (!rd_done_q) begin
          src_rd_en = 1'b1;
          wr_vld_d  = 1'b1;
          wr_w_d    = w_q;
          if (w_q == last_w) begin
            rd_done_d = 1'b1;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
        // Write side trails the read by one cycle, using the returned data.
        if (wr_vld_q) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = wr_addr;
          tpu_dataIn = src_rdata;
          if (wr_w_q == last_w) begin
            w_d       = '0;
            rd_done_d = 1'b0;
            wr_w_d    = '0;
            state_d   = StTrig;
          end
        end
      end

      StTrig: begin
        // Exactly one cycle: a longer trigger would restart the TPU's counter.
        tpu_addr = TrigAddr;
        wait_d   = '0;
        state_d  = StWait;
      end

      StWait: begin
        if (wait_q == LastWait) begin
          wait_d  = '0;
          k_d     = '0;
          state_d = StRdc;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StRdc: begin
        res_valid = 1'b1;
        tpu_addr  = BaseC | (ADDRW'(k_q) << 3);
        res_data  = tpu_dataOut;
        if (res_ready) begin
          if (k_q == LastRes) begin
            k_d     = '0;
            state_d = StDone;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      load_c_q  <= 1'b0;
      w_q       <= '0;
      rd_done_q <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_w_q    <= '0;
      wait_q    <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      load_c_q  <= load_c_d;
      w_q       <= w_d;
      rd_done_q <= rd_done_d;
      wr_vld_q  <= wr_vld_d;
      wr_w_q    <= wr_w_d;
      wait_q    <= wait_d;
      k_q       <= k_d;
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Bench for tpu_host_seq: source RAM and TPU slave models plus a job-level
// reference (expected bus log, cycle timing and C = C0 + A*B result).
module tb_tpu_host_seq;

  localparam int DIM = 8;
  localparam int NW  = 4 * DIM;
  localparam int NC  = 2 * DIM;
  localparam int MM  = 4 * DIM;

  logic        clk = 1'b0;
  logic        rst, start, load_c, res_ready;
  logic        busy, done, src_rd_en, tpu_r_w, res_valid;
  logic [4:0]  src_addr;
  logic [3:0]  res_idx;
  logic [15:0] tpu_addr;
  logic [63:0] src_rdata, tpu_dataIn, tpu_dataOut, res_data;

  logic [63:0] src_mem [NW];
  logic [63:0] tpu_a [DIM];
  logic [63:0] tpu_b [DIM];
  logic [63:0] tpu_c [NC];
  logic [63:0] ref_c [NC];
  logic [63:0] exp_c [NC];

  int n_checks = 0;
  int n_errors = 0;
  int rel;

  // Monitor state for one job.
  bit          mon_on;
  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  int          ri_q[$];
  logic [15:0] ra_q[$];
  logic [63:0] rd_q[$];
  int trig_n, trig_cyc, first_rd, bus_bad, done_n, done_cyc, stab_err, c3_n;
  logic busy0, busy1;
  bit   prev_stall;
  logic [15:0] p_addr;
  logic [63:0] p_data;
  logic [3:0]  p_idx;
  bit rdy_hist [4096];

  tpu_host_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_c     (load_c),
    .busy       (busy),
    .done       (done),
    .src_rd_en  (src_rd_en),
    .src_addr   (src_addr),
    .src_rdata  (src_rdata),
    .tpu_r_w    (tpu_r_w),
    .tpu_addr   (tpu_addr),
    .tpu_dataIn (tpu_dataIn),
    .tpu_dataOut(tpu_dataOut),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_idx    (res_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= src_mem[src_addr];
  end

  assign tpu_dataOut = tpu_c[tpu_addr[6:3]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // New C half-row k: previous half plus row (k>>1) of A*B, 8-bit elements,
  // 16-bit accumulators, four columns per half.
  function automatic logic [63:0] c_half(input logic [63:0] a [DIM], input logic [63:0] b [DIM],
                                         input logic [63:0] prev, input int k);
    logic [63:0] res;
    logic [15:0] acc;
    int r, col;
    r   = k / 2;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      col = 4 * (k % 2) + j;
      acc = prev[16*j +: 16];
      for (int m = 0; m < DIM; m++) begin
        acc = acc + 16'(a[r][8*m +: 8]) * 16'(b[m][8*col +: 8]);
      end
      res[16*j +: 16] = acc;
    end
    return res;
  endfunction

  function automatic logic [15:0] exp_waddr(input int w);
    if (w < DIM) return 16'(32'h100 + 8 * w);
    else if (w < 2 * DIM) return 16'(32'h200 + 8 * (w - DIM));
    else return 16'(32'h300 + 8 * (w - 2 * DIM));
  endfunction

  task automatic tpu_model();
    logic [63:0] nc [NC];
    if (tpu_r_w === 1'b1) begin
      case (tpu_addr[11:8])
        4'h1: tpu_a[tpu_addr[5:3]] = tpu_dataIn;
        4'h2: tpu_b[tpu_addr[5:3]] = tpu_dataIn;
        4'h3: tpu_c[tpu_addr[6:3]] = tpu_dataIn;
        default: ;
      endcase
    end else if (tpu_addr === 16'h0400) begin
      for (int k = 0; k < NC; k++) nc[k] = c_half(tpu_a, tpu_b, tpu_c[k], k);
      for (int k = 0; k < NC; k++) tpu_c[k] = nc[k];
    end
  endtask

  task automatic sample();
    if (rel == 0) busy0 = busy;
    if (rel == 1) busy1 = busy;
    if (done === 1'b1) begin
      done_n++;
      done_cyc = rel;
    end
    if (tpu_r_w === 1'b1) begin
      wa_q.push_back(tpu_addr);
      wd_q.push_back(tpu_dataIn);
      if (tpu_addr[11:8] == 4'h3) c3_n++;
    end else if (tpu_addr === 16'h0400) begin
      trig_n++;
      trig_cyc = rel;
      if (tpu_dataIn !== 64'd0) bus_bad++;
    end else if (res_valid === 1'b1) begin
      if (first_rd < 0) first_rd = rel;
      if (prev_stall && (tpu_addr !== p_addr || res_data !== p_data || res_idx !== p_idx))
        stab_err++;
      if (res_ready) begin
        ri_q.push_back(int'(res_idx));
        ra_q.push_back(tpu_addr);
        rd_q.push_back(res_data);
      end
    end else if (tpu_addr !== 16'd0 || tpu_dataIn !== 64'd0) begin
      bus_bad++;
    end
    prev_stall = (res_valid === 1'b1) && !res_ready;
    p_addr = tpu_addr;
    p_data = res_data;
    p_idx  = res_idx;
  endtask

  task automatic step();
    @(negedge clk);
    if (mon_on) sample();
    tpu_model();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic drive_ready(input int mode);
    case (mode)
      0: res_ready = 1'b1;
      1: res_ready = ((rel % 4) == 0) || ((rel % 4) == 3);
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
    if (rel >= 0 && rel < 4096) rdy_hist[rel] = res_ready;
  endtask

  task automatic run_job(input string name, input logic lc, input int mode, input int p1,
                         input int p2, input int abort_at);
    logic [63:0] sa [DIM];
    logic [63:0] sb [DIM];
    int nw, exp_trig, exp_rd, exp_done, k, c;
    bit timed_out;

    for (int i = 0; i < DIM; i++) begin
      sa[i] = src_mem[i];
      sb[i] = src_mem[DIM + i];
    end
    for (int i = 0; i < NC; i++)
      exp_c[i] = c_half(sa, sb, lc ? src_mem[2 * DIM + i] : ref_c[i], i);
    nw = lc ? NW : 2 * DIM;

    wa_q.delete(); wd_q.delete(); ri_q.delete(); ra_q.delete(); rd_q.delete();
    trig_n = 0; trig_cyc = -1; first_rd = -1; bus_bad = 0; done_n = 0; done_cyc = -1;
    stab_err = 0; c3_n = 0; prev_stall = 0; busy0 = 1'bx; busy1 = 1'bx;
    for (int i = 0; i < 4096; i++) rdy_hist[i] = 0;

    mon_on = 1; rel = 0; start = 1'b1; load_c = lc;
    drive_ready(mode);
    timed_out = 1;
    for (int n = 0; n < 3000; n++) begin
      step();
      start  = (rel == p1) || (rel == p2);
      load_c = 1'($urandom_range(0, 1));
      drive_ready(mode);
      if (abort_at >= 0 && rel == abort_at) rst = 1'b1;
      if (abort_at >= 0 && rel == abort_at + 1) begin
        rst = 1'b0;
        mon_on = 0;
        check({name, "_abort_busy"}, 64'(busy), 64'd0);
        check({name, "_abort_rw"}, 64'(tpu_r_w), 64'd0);
        check({name, "_abort_addr"}, 64'(tpu_addr), 64'd0);
        check({name, "_abort_din"}, tpu_dataIn, 64'd0);
        check({name, "_abort_rden"}, 64'(src_rd_en), 64'd0);
        check({name, "_abort_rvalid"}, 64'(res_valid), 64'd0);
        return;
      end
      if (done_n > 0 && rel == done_cyc + 1) begin
        timed_out = 0;
        break;
      end
    end
    mon_on = 0;
    start  = 1'b0;
    check({name, "_timeout"}, 64'(timed_out), 64'd0);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
    if (timed_out) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end

    check({name, "_busy0"}, 64'(busy0), 64'd0);
    check({name, "_busy1"}, 64'(busy1), 64'd1);
    check({name, "_wcount"}, 64'(wa_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      check($sformatf("%s_waddr%0d", name, i), 64'(wa_q[i]), 64'(exp_waddr(i)));
      check($sformatf("%s_wdata%0d", name, i), wd_q[i], src_mem[i]);
    end
    check({name, "_c_writes"}, 64'(c3_n), lc ? 64'(NC) : 64'd0);
    check({name, "_trig_n"}, 64'(trig_n), 64'd1);
    exp_trig = nw + 2;
    check({name, "_trig_cyc"}, 64'(trig_cyc), 64'(exp_trig));
    exp_rd = exp_trig + 1 + MM;
    check({name, "_first_rd"}, 64'(first_rd), 64'(exp_rd));
    check({name, "_idle_bus"}, 64'(bus_bad), 64'd0);
    check({name, "_rcount"}, 64'(ri_q.size()), 64'(NC));
    for (int i = 0; i < NC && i < ri_q.size(); i++) begin
      check($sformatf("%s_ridx%0d", name, i), 64'(ri_q[i]), 64'(i));
      check($sformatf("%s_raddr%0d", name, i), 64'(ra_q[i]), 64'(32'h300 + 8 * i));
      check($sformatf("%s_rdata%0d", name, i), rd_q[i], exp_c[i]);
    end
    check({name, "_stall_stable"}, 64'(stab_err), 64'd0);
    check({name, "_done_n"}, 64'(done_n), 64'd1);
    k = 0;
    c = exp_rd;
    while (c < 4000) begin
      if (rdy_hist[c]) begin
        k++;
        if (k == NC) break;
      end
      c++;
    end
    exp_done = c + 1;
    check({name, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
    for (int i = 0; i < NC; i++) ref_c[i] = exp_c[i];
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) src_mem[i] = {$urandom, $urandom};
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      tpu_c[i] = '0;
      ref_c[i] = '0;
    end
    for (int i = 0; i < DIM; i++) begin
      tpu_a[i] = '0;
      tpu_b[i] = '0;
    end
    mon_on = 0;
    rel = 0;
    rst = 1'b1; start = 1'b1; load_c = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rw", 64'(tpu_r_w), 64'd0);
    check("rst_addr", 64'(tpu_addr), 64'd0);
    check("rst_rvalid", 64'(res_valid), 64'd0);
    rst = 1'b0; start = 1'b0;
    repeat (3) step();
    check("rst_nostart", 64'(busy), 64'd0);

    for (int i = 0; i < NW; i++)
      src_mem[i] = 64'h1111_0000_0000_0000 * 64'(i) + 64'(i);
    run_job("full", 1'b1, 0, -1, -1, -1);

    fill_random();
    run_job("noc", 1'b0, 0, 30, 55, -1);

    fill_random();
    run_job("bp", 1'b1, 1, 40, 80, -1);

    fill_random();
    run_job("abort", 1'b1, 0, -1, -1, 20);
    repeat (2) step();

    fill_random();
    run_job("after_rst", 1'b1, 2, -1, -1, -1);

    fill_random();
    run_job("noc2", 1'b0, 0, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
